// File: rtl/fp_fixed_convert_pipe.sv
// Three-stage converter between IEEE-754 single precision and WL-bit fixed point
// (FRAC fraction bits, signed or unsigned), one operation per enabled cycle.
module fp_fixed_convert_pipe #(
  parameter int WL     = 21,
  parameter int FRAC   = 20,
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        ovf,
  output logic        unf
);
  // Handshake: an op is accepted on every rising edge with clk_en=1 and start=1
  // (no back-pressure); done pulses for one enabled cycle exactly three enabled
  // edges later, with result/ovf/unf valid alongside and held until the next done.
  localparam int SW = WL + 25;
  localparam logic [SW-1:0] POS_MAX = (SW'(1) << ((SIGNED != 0) ? WL - 1 : WL)) - SW'(1);
  localparam logic [SW-1:0] NEG_MAG = SW'(1) << (WL - 1);

  logic [7:0]    in_exp;
  logic [22:0]   in_frac;
  logic [WL-1:0] in_fx;
  assign in_exp  = dataa[30:23];
  assign in_frac = dataa[22:0];
  assign in_fx   = dataa[WL-1:0];

  // S1: unpack and classify the float, or take the absolute value of the fixed input
  logic          c1_sign, c1_zero, c1_tiny, c1_inf, c1_nan;
  logic [9:0]    c1_sh;
  logic [WL:0]   c1_fmag;

  always_comb begin
    c1_sign = 1'b0;
    c1_zero = 1'b0;
    c1_tiny = 1'b0;
    c1_inf  = 1'b0;
    c1_nan  = 1'b0;
    c1_sh   = {2'b00, in_exp} - 10'd150 + 10'(FRAC);
    c1_fmag = {1'b0, in_fx};
    if (mode) begin
      c1_zero = (in_fx == '0);
      if (SIGNED != 0 && in_fx[WL-1]) begin
        c1_sign = 1'b1;
        c1_fmag = -{1'b1, in_fx};
      end
    end else begin
      c1_sign = dataa[31];
      c1_zero = (in_exp == 8'd0);
      c1_tiny = (in_exp == 8'd0) && (in_frac != '0);
      c1_inf  = (in_exp == 8'hFF) && (in_frac == '0);
      c1_nan  = (in_exp == 8'hFF) && (in_frac != '0);
    end
  end

  logic              s1_valid, s1_mode, s1_sign, s1_zero, s1_tiny, s1_inf, s1_nan;
  logic signed [9:0] s1_sh;
  logic [23:0]       s1_mant;
  logic [WL:0]       s1_fmag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_tiny  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_sh    <= '0;
      s1_mant  <= '0;
      s1_fmag  <= '0;
    end else if (clk_en) begin
      s1_valid <= start;
      s1_mode  <= mode;
      s1_sign  <= c1_sign;
      s1_zero  <= c1_zero;
      s1_tiny  <= c1_tiny;
      s1_inf   <= c1_inf;
      s1_nan   <= c1_nan;
      s1_sh    <= signed'(c1_sh);
      s1_mant  <= {1'b1, in_frac};
      s1_fmag  <= c1_fmag;
    end
  end

  // S2: scale the significand into fixed point, or find the leading one
  logic signed [9:0] nsh;
  logic              c2_big;
  logic [SW-1:0]     c2_mag;
  logic [5:0]        c2_p;

  always_comb begin
    nsh    = -s1_sh;
    c2_big = 1'b0;
    c2_mag = '0;
    c2_p   = '0;
    if (s1_mode) begin
      c2_mag = SW'(s1_fmag);
      for (int i = 0; i <= WL; i++) begin
        if (s1_fmag[i]) c2_p = 6'(i);
      end
    end else if (s1_sh >= 0) begin
      // Beyond WL the value exceeds every bound, so flag it instead of shifting
      if (s1_sh > WL) c2_big = 1'b1;
      else            c2_mag = SW'(s1_mant) << s1_sh[5:0];
    end else if (nsh < 24) begin
      c2_mag = SW'(s1_mant) >> nsh[4:0];
    end
  end

  logic          s2_valid, s2_mode, s2_sign, s2_zero, s2_tiny, s2_inf, s2_nan, s2_big;
  logic [SW-1:0] s2_mag;
  logic [5:0]    s2_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_tiny  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_nan   <= 1'b0;
      s2_big   <= 1'b0;
      s2_mag   <= '0;
      s2_p     <= '0;
    end else if (clk_en) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_tiny  <= s1_tiny;
      s2_inf   <= s1_inf;
      s2_nan   <= s1_nan;
      s2_big   <= c2_big;
      s2_mag   <= c2_mag;
      s2_p     <= c2_p;
    end
  end

  // S3: saturate/negate the fixed result, or normalise and pack the float
  logic [WL-1:0] c3_fx;
  logic [31:0]   c3_res;
  logic          c3_ovf, c3_unf;

  always_comb begin
    c3_fx  = '0;
    c3_res = '0;
    c3_ovf = 1'b0;
    c3_unf = 1'b0;
    if (s2_mode) begin
      // Shift the leading one to the top of the SW-bit word, keep the 23 bits below it
      if (!s2_zero)
        c3_res = {s2_sign, 8'(127 + int'(s2_p) - FRAC),
                  23'(((s2_mag << 24) << (WL - int'(s2_p))) >> (SW - 24))};
    end else begin
      if (s2_zero) begin
        c3_unf = s2_tiny;
      end else if (s2_nan) begin
        c3_fx  = POS_MAX[WL-1:0];
        c3_ovf = 1'b1;
      end else if (s2_sign && SIGNED == 0) begin
        c3_ovf = 1'b1;
      end else if (s2_sign) begin
        if (s2_inf || s2_big || s2_mag > NEG_MAG) begin
          c3_fx  = NEG_MAG[WL-1:0];
          c3_ovf = 1'b1;
        end else begin
          c3_fx  = -s2_mag[WL-1:0];
          c3_unf = (s2_mag == '0);
        end
      end else if (s2_inf || s2_big || s2_mag > POS_MAX) begin
        c3_fx  = POS_MAX[WL-1:0];
        c3_ovf = 1'b1;
      end else begin
        c3_fx  = s2_mag[WL-1:0];
        c3_unf = (s2_mag == '0);
      end
      if (SIGNED != 0) c3_res = 32'(signed'(c3_fx));
      else             c3_res = 32'(c3_fx);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (clk_en) begin
      done <= s2_valid;
      if (s2_valid) begin
        result <= c3_res;
        ovf    <= c3_ovf;
        unf    <= c3_unf;
      end
    end
  end
endmodule

// File: tb/tb_fp_fixed_convert_pipe.sv
// Directed bench for fp_fixed_convert_pipe: a signed WL=21/FRAC=20 instance and an
// unsigned WL=16/FRAC=8 instance, each with an expected-response queue and monitor.
module tb_fp_fixed_convert_pipe;
  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b1;
  always #5 clk = ~clk;

  logic        start_s = 1'b0, mode_s = 1'b0;
  logic [31:0] dataa_s = '0;
  logic [31:0] result_s;
  logic        done_s, ovf_s, unf_s;
  logic        start_u = 1'b0, mode_u = 1'b0;
  logic [31:0] dataa_u = '0;
  logic [31:0] result_u;
  logic        done_u, ovf_u, unf_u;

  fp_fixed_convert_pipe #(.WL(21), .FRAC(20), .SIGNED(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start_s), .mode(mode_s),
    .dataa(dataa_s), .result(result_s), .done(done_s), .ovf(ovf_s), .unf(unf_s));

  fp_fixed_convert_pipe #(.WL(16), .FRAC(8), .SIGNED(0)) dut_u (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start_u), .mode(mode_u),
    .dataa(dataa_u), .result(result_u), .done(done_u), .ovf(ovf_u), .unf(unf_u));

  // scoreboard: {result[31:0], ovf, unf, issue_count[31:0]}
  logic [65:0] exp_s_q[$];
  logic [65:0] exp_u_q[$];
  logic [65:0] e_s, e_u;
  logic [31:0] last_s = '0, last_u = '0;
  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  logic last_en = 1'b0;

  always @(posedge clk) begin
    if (clk_en) en_cnt <= en_cnt + 1;
    last_en <= clk_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: called just after a falling edge; start is held until the op is sampled
  task automatic issue(input bit sel, input bit m, input logic [31:0] d,
                       input logic [31:0] r, input bit o, input bit u, input int freeze);
    if (!sel) begin
      start_s = 1'b1; mode_s = m; dataa_s = d;
      exp_s_q.push_back({r, o, u, 32'(en_cnt)});
    end else begin
      start_u = 1'b1; mode_u = m; dataa_u = d;
      exp_u_q.push_back({r, o, u, 32'(en_cnt)});
    end
    if (freeze > 0) begin
      clk_en = 1'b0;
      repeat (freeze) @(negedge clk);
      clk_en = 1'b1;
    end
    @(negedge clk);
    start_s = 1'b0;
    start_u = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_s_q.size() + exp_u_q.size()) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((exp_s_q.size() + exp_u_q.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d ops outstanding, expected 0", exp_s_q.size() + exp_u_q.size());
      exp_s_q.delete();
      exp_u_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // monitors: a done seen after an enabled edge is a new completion
  always @(negedge clk) begin
    if (reset_n && last_en) begin
      if (done_s) begin
        if (exp_s_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_unexpected_done: got result 0x%08h, expected no done", result_s);
        end else begin
          e_s = exp_s_q.pop_front();
          check("s_result", result_s, e_s[65:34]);
          check("s_ovf", {31'b0, ovf_s}, {31'b0, e_s[33]});
          check("s_unf", {31'b0, unf_s}, {31'b0, e_s[32]});
          check("s_latency", 32'(en_cnt), e_s[31:0] + 32'd3);
          last_s = e_s[65:34];
        end
      end else begin
        check("s_hold", result_s, last_s);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && last_en) begin
      if (done_u) begin
        if (exp_u_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL u_unexpected_done: got result 0x%08h, expected no done", result_u);
        end else begin
          e_u = exp_u_q.pop_front();
          check("u_result", result_u, e_u[65:34]);
          check("u_ovf", {31'b0, ovf_u}, {31'b0, e_u[33]});
          check("u_unf", {31'b0, unf_u}, {31'b0, e_u[32]});
          check("u_latency", 32'(en_cnt), e_u[31:0] + 32'd3);
          last_u = e_u[65:34];
        end
      end else begin
        check("u_hold", result_u, last_u);
      end
    end
  end

  initial begin
    #1;
    check("rst_result", result_s, 32'h0);
    check("rst_done", {31'b0, done_s}, 32'h0);
    check("rst_flags", {30'b0, ovf_s, unf_s}, 32'h0);
    check("rst_u_result", result_u, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // float -> fixed, signed Q1.20 in 21 bits
    issue(0, 0, 32'h3F000000, 32'h00080000, 0, 0, 0);
    issue(0, 0, 32'hBF000000, 32'hFFF80000, 0, 0, 0);
    issue(0, 0, 32'h3F800000, 32'h000FFFFF, 1, 0, 0);
    issue(0, 0, 32'hBF800000, 32'hFFF00000, 0, 0, 0);
    issue(0, 0, 32'h7FC00000, 32'h000FFFFF, 1, 0, 0);
    issue(0, 0, 32'h30800000, 32'h00000000, 0, 1, 0);
    issue(0, 0, 32'h3F7FFFFF, 32'h000FFFFF, 0, 0, 0);
    issue(0, 0, 32'hC0000000, 32'hFFF00000, 1, 0, 0);
    issue(0, 0, 32'hFF800000, 32'hFFF00000, 1, 0, 0);
    issue(0, 0, 32'h7F800000, 32'h000FFFFF, 1, 0, 0);
    issue(0, 0, 32'h80000000, 32'h00000000, 0, 0, 0);
    issue(0, 0, 32'h00000001, 32'h00000000, 0, 1, 0);
    // fixed -> float
    issue(0, 1, 32'h00040000, 32'h3E800000, 0, 0, 0);
    issue(0, 1, 32'h00100000, 32'hBF800000, 0, 0, 0);
    issue(0, 1, 32'h00000000, 32'h00000000, 0, 0, 0);
    issue(0, 1, 32'h000FFFFF, 32'h3F7FFFF0, 0, 0, 0);
    issue(0, 1, 32'h001FFFFF, 32'hB5800000, 0, 0, 0);
    issue(0, 1, 32'h00000001, 32'h35800000, 0, 0, 0);
    issue(0, 1, 32'hFFE40000, 32'h3E800000, 0, 0, 0);
    // unsigned Q8.8 in 16 bits
    issue(1, 0, 32'h437F0000, 32'h0000FF00, 0, 0, 0);
    issue(1, 0, 32'hBF800000, 32'h00000000, 1, 0, 0);
    issue(1, 1, 32'h0000FFFF, 32'h437FFF00, 0, 0, 0);
    issue(1, 0, 32'h477FFF00, 32'h0000FFFF, 1, 0, 0);
    issue(1, 0, 32'h3B800000, 32'h00000001, 0, 0, 0);
    issue(1, 0, 32'h3B000000, 32'h00000000, 0, 1, 0);
    drain();

    // mixed modes back to back, pipeline frozen for two cycles with start held
    issue(0, 0, 32'h3E800000, 32'h00040000, 0, 0, 0);
    issue(0, 1, 32'h00040000, 32'h3E800000, 0, 0, 0);
    issue(0, 0, 32'hBF000000, 32'hFFF80000, 0, 0, 2);
    issue(0, 1, 32'h001FFFFF, 32'hB5800000, 0, 0, 0);
    issue(0, 0, 32'h4F000000, 32'h000FFFFF, 1, 0, 0);
    drain();

    // reset with two ops in flight, and a start presented during reset
    issue(0, 0, 32'h3F000000, 32'h00080000, 0, 0, 0);
    issue(0, 1, 32'h00100000, 32'hBF800000, 0, 0, 0);
    #3 reset_n = 1'b0;
    exp_s_q.delete();
    last_s = '0;
    #1;
    check("midrst_result", result_s, 32'h0);
    check("midrst_done", {31'b0, done_s}, 32'h0);
    check("midrst_flags", {30'b0, ovf_s, unf_s}, 32'h0);
    @(negedge clk);
    start_s = 1'b1; mode_s = 1'b0; dataa_s = 32'h3F800000;
    @(negedge clk);
    start_s = 1'b0;
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 0, 32'hBF800000, 32'hFFF00000, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
